// File: rtl/const_mul_pkg.sv
// Shared definitions for the constant-coefficient multiply sequencer.
//   state_t      : sequencer states (IDLE, MUL, OUT)
//   out_width()  : product width for a DW-bit operand times a CW-bit coefficient
//   COEF_DEFAULT : default coefficient set {8,7,3,1}, coefficient 0 in the LSB slice
package const_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // An unsigned DW x CW product never needs more than DW+CW bits.
    function automatic int out_width(input int dw, input int cw);
        return dw + cw;
    endfunction

    localparam logic [15:0] COEF_DEFAULT = {4'd8, 4'd7, 4'd3, 4'd1};

endpackage

// File: rtl/shift_add_step.sv
// One step of the serial shift-add multiplier.
//   acc_i      : running partial product
//   d_i        : latched operand
//   bit_i      : coefficient bit position being processed
//   coef_bit_i : value of that coefficient bit
//   acc_o      : acc_i + (d_i << bit_i) when coef_bit_i is set, else acc_i
module shift_add_step
    import const_mul_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int CW = 4,
    parameter  int BW = 2,
    localparam int OW = out_width(DW, CW)
) (
    input  logic [OW-1:0] acc_i,
    input  logic [DW-1:0] d_i,
    input  logic [BW-1:0] bit_i,
    input  logic          coef_bit_i,
    output logic [OW-1:0] acc_o
);

    logic [OW-1:0] addend;

    always_comb begin
        // Operand is zero-extended to OW before shifting so no bits fall off.
        addend = {{CW{1'b0}}, d_i} << bit_i;
        acc_o  = coef_bit_i ? (acc_i + addend) : acc_i;
    end

endmodule

// File: rtl/const_mul_seq.sv
// Constant-coefficient multiply sequencer.
// Accepts one unsigned operand, multiplies it by each of NCOEF constant
// coefficients in turn (serial shift-add, CW cycles per product) and streams
// the products out with index and last tag.
//   clk, rst                  : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : operand handshake (accepted only in IDLE)
//   out_valid/out_ready       : product handshake with backpressure
//   out_data/out_idx/out_last : product, coefficient index, final-product flag
//   busy                      : high whenever not IDLE
//   dbg_state                 : current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once out_valid rises, out_valid/out_data/out_idx/out_last stay
// unchanged until that transfer edge.
module const_mul_seq
    import const_mul_pkg::*;
#(
    parameter  int                   DW    = 8,
    parameter  int                   CW    = 4,
    parameter  int                   NCOEF = 4,
    parameter  logic [NCOEF*CW-1:0]  COEF  = COEF_DEFAULT,
    localparam int                   OW    = out_width(DW, CW),
    localparam int                   IW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output state_t        dbg_state
);

    localparam int            BW       = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [IW-1:0] K_LAST   = IW'(NCOEF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CW - 1);

    state_t        state_q,     state_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] d_q,         d_d;
    logic [IW-1:0] k_q,         k_d;
    logic [OW-1:0] acc_q,       acc_d;
    logic [BW-1:0] bit_q,       bit_d;
    logic [OW-1:0] out_data_q,  out_data_d;
    logic          out_last_q,  out_last_d;

    // Coefficient table unpacked from the flat parameter vector.
    logic [CW-1:0] coef_arr [NCOEF];
    for (genvar g = 0; g < NCOEF; g++) begin : g_coef
        assign coef_arr[g] = COEF[g*CW +: CW];
    end

    logic          coef_bit;
    logic [OW-1:0] step_acc;

    assign coef_bit = coef_arr[k_q][bit_q];

    shift_add_step #(
        .DW (DW),
        .CW (CW),
        .BW (BW)
    ) u_step (
        .acc_i      (acc_q),
        .d_i        (d_q),
        .bit_i      (bit_q),
        .coef_bit_i (coef_bit),
        .acc_o      (step_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            bit_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            bit_q       <= bit_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        d_d         = d_q;
        k_d         = k_q;
        acc_d       = acc_q;
        bit_d       = bit_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            IDLE: begin
                // in_ready comes up one edge after reset release and stays up
                // until an operand is taken.
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    d_d        = in_data;
                    k_d        = '0;
                    acc_d      = '0;
                    bit_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
                end
            end

            MUL: begin
                acc_d = step_acc;
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_LAST) begin
                    out_data_d  = step_acc;
                    out_last_d  = (k_q == K_LAST);
                    out_valid_d = 1'b1;
                    bit_d       = '0;
                    state_d     = OUT;
                end
            end

            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        acc_d   = '0;
                        bit_d   = '0;
                        state_d = MUL;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    // k only advances on a handshake, so it is the index of the product on show.
    assign out_idx   = k_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_const_mul_seq.sv
module tb_const_mul_seq;
    import const_mul_pkg::*;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int NCOEF = 4;
    localparam int OW    = DW + CW;
    localparam int IW    = 2;
    localparam int EW    = 1 + IW + OW;

    // Coefficients k = 0..NCOEF-1 of the default set.
    int COEFS  [NCOEF] = '{1, 3, 7, 8};
    int COEFS2 [2]     = '{0, 15};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT 0 (defaults) ----------------
    logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_data;
    logic [IW-1:0] out_idx;
    state_t        dbg_state;

    const_mul_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- DUT 1 (NCOEF=2, COEF={15,0}) ----------------
    logic          in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
    logic [DW-1:0] in_data2;
    logic [OW-1:0] out_data2;
    logic [0:0]    out_idx2;
    state_t        dbg_state2;

    const_mul_seq #(
        .DW    (8),
        .CW    (4),
        .NCOEF (2),
        .COEF  ({4'd15, 4'd0})
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_idx   (out_idx2),
        .out_last  (out_last2),
        .busy      (busy2),
        .dbg_state (dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_err    = 0;
    logic [EW-1:0] exp_q[$];
    logic          prev_hold;
    logic [EW-1:0] prev_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock of DUT 0: note handshakes before the edge, update the model,
    // then check outputs after the edge.
    task automatic cycle();
        logic          hs, acc;
        logic [DW-1:0] op;
        hs        = out_valid && out_ready;
        acc       = in_valid && in_ready;
        op        = in_data;
        prev_hold = out_valid && !out_ready;
        prev_obs  = {out_last, out_idx, out_data};
        tick();
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            for (int k = 0; k < NCOEF; k++)
                exp_q.push_back({(k == NCOEF - 1), IW'(k), OW'(int'(op) * COEFS[k])});
        end
        if (busy) check("ready_while_busy", 32'(in_ready), 32'(0));
        if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_payload", 32'({out_last, out_idx, out_data}), 32'(prev_obs));
        end
        if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'(0));
            else check("payload", 32'({out_last, out_idx, out_data}), 32'(exp_q[0]));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            cycle();
            n++;
        end
        check("wait_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || !in_ready) && n < 400) begin
            cycle();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic run_op(input logic [DW-1:0] op);
        wait_ready();
        in_valid = 1'b1;
        in_data  = op;
        cycle();
        in_valid = 1'b0;
        drain();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_out_idx",   32'(out_idx),   32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        check("ready_before_edge", 32'(in_ready), 32'(0));
        cycle();
        check("ready_after_release", 32'(in_ready), 32'(1));

        // Operand 5 with full-rate consumer: latency and operand period
        in_valid = 1'b1;
        in_data  = 8'd5;
        cycle();
        in_valid = 1'b0;
        check("state_after_accept", 32'(dbg_state), 32'(MUL));
        t = 0;
        while (!out_valid && t < 60) begin
            cycle();
            t++;
        end
        check("first_valid_latency", 32'(t), 32'(CW));
        check("first_product_5", 32'(out_data), 32'(5));
        while (!in_ready && t < 200) begin
            cycle();
            t++;
        end
        check("ready_return_edges", 32'(t), 32'(NCOEF * (CW + 1)));
        check("drain_op5", 32'(exp_q.size()), 32'(0));

        // Extremes
        run_op(8'd255);
        run_op(8'd0);

        // Backpressure on idx 1 of operand 5
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'd5;
        cycle();
        in_valid = 1'b0;
        t = 0;
        while (!(out_valid && out_idx == 2'd1) && t < 100) begin
            cycle();
            t++;
        end
        check("stall_idx", 32'(out_idx), 32'(1));
        out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("stall_data", 32'(out_data), 32'(15));
        end
        out_ready = 1'b1;
        cycle();
        check("after_release_valid", 32'(out_valid), 32'(0));
        drain();

        // in_valid held high, data changing every cycle, random backpressure
        in_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of the second coefficient's multiply
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'd5;
        cycle();
        in_valid = 1'b0;
        t = 0;
        while (!(out_valid && out_idx == 2'd0) && t < 60) begin
            cycle();
            t++;
        end
        cycle();
        cycle();
        check("mid_mul_state", 32'(dbg_state), 32'(MUL));
        rst = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'(0));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_out_data",  32'(out_data),  32'(0));
        check("arst_out_idx",   32'(out_idx),   32'(0));
        check("arst_out_last",  32'(out_last),  32'(0));
        check("arst_busy",      32'(busy),      32'(0));
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        check("arst_ready_pre", 32'(in_ready), 32'(0));
        cycle();
        check("arst_ready_post", 32'(in_ready), 32'(1));
        run_op(8'd3);

        // Overridden coefficient set {0, 15} with operand 200
        t = 0;
        while (!in_ready2 && t < 50) begin
            tick();
            t++;
        end
        check("ov_ready", 32'(in_ready2), 32'(1));
        in_valid2 = 1'b1;
        in_data2  = 8'd200;
        tick();
        in_valid2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!out_valid2 && t < 60) begin
                tick();
                t++;
            end
            check("ov_latency", 32'(t), 32'(CW));
            check("ov_data", 32'(out_data2), 32'(200 * COEFS2[k]));
            check("ov_idx",  32'(out_idx2),  32'(k));
            check("ov_last", 32'(out_last2), 32'(k == 1));
            tick();
        end
        check("ov_ready_back", 32'(in_ready2), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
